// File: rtl/centronics_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : centronics_rx_if
//  Description : Bundles the Centronics host-side handshake (strobe, data,
//                busy, ack) together with the byte stream presented toward
//                the MCU/SPI sink (rx_data / rx_valid / rx_ready).
//                master : host + sink side (drives strobe/data/ready)
//                slave  : the printer-end responder (drives busy/ack/stream)
//  Revision    : 1.0 - initial release
// ============================================================================
interface centronics_rx_if;
  logic       pp_strobe_n;
  logic [7:0] pp_data;
  logic       pp_busy;
  logic       pp_ack_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output pp_strobe_n,
    output pp_data,
    output rx_ready,
    input  pp_busy,
    input  pp_ack_n,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  pp_strobe_n,
    input  pp_data,
    input  rx_ready,
    output pp_busy,
    output pp_ack_n,
    output rx_data,
    output rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/centronics_rx.sv
`default_nettype none
// ============================================================================
//  Module      : centronics_rx
//  Description : Printer-end Centronics parallel-port responder. Qualifies
//                the host strobe with a glitch filter, captures the data
//                byte into a first-word-fall-through FIFO, paces the host
//                with busy/ack and presents bytes on a valid/ready stream.
//  Ports       : clk32        - 32 MHz clock, the only clock
//                reset_n      - asynchronous active-low reset
//                enable       - receiver enable (0: strobes ignored, busy=1)
//                bus          - host handshake + sink stream (slave modport)
//                fifo_level   - current FIFO occupancy
//                overrun      - sticky: a captured byte was dropped
//                overrun_clr  - clears overrun (a same-cycle set wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module centronics_rx #(
  parameter int FIFO_DEPTH = 16,  // power of 2, >= 2
  parameter int STROBE_MIN = 8,   // qualifying low samples, >= 2
  parameter int ACK_CYCLES = 160  // ack pulse width in clk32 cycles
) (
  input  logic                        clk32,
  input  logic                        reset_n,
  input  logic                        enable,
  centronics_rx_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int QW = $clog2(STROBE_MIN + 1);
  localparam int AW = $clog2(ACK_CYCLES + 1);

  localparam logic [QW-1:0] QUAL_LAST  = QW'(STROBE_MIN);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    WAIT_HI = 2'd2,
    ACK     = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers. Data is synchronized alongside the strobe; the
  // host holds it stable for the whole strobe, so by the time the strobe has
  // been qualified the synchronized byte is settled.
  // --------------------------------------------------------------------------
  logic       strobe_meta;
  logic       s_strobe_n;
  logic [7:0] data_meta;
  logic [7:0] s_data;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      strobe_meta <= 1'b1;
      s_strobe_n  <= 1'b1;
      data_meta   <= 8'h00;
      s_data      <= 8'h00;
    end else begin
      strobe_meta <= bus.pp_strobe_n;
      s_strobe_n  <= strobe_meta;
      data_meta   <= bus.pp_data;
      s_data      <= data_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  state_t          state;
  state_t          state_next;
  logic [QW-1:0]   qual_cnt;
  logic [QW-1:0]   qual_next;
  logic [AW-1:0]   ack_cnt;
  logic [AW-1:0]   ack_next;
  logic            capture;
  logic            busy_next;
  logic            ack_n_next;
  logic            busy;
  logic            ack_n;

  logic            full;
  logic            wr_en;
  logic            rd_en;
  logic            drop;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      qual_cnt <= '0;
      ack_cnt  <= '0;
      busy     <= 1'b1;
      ack_n    <= 1'b1;
    end else begin
      state    <= state_next;
      qual_cnt <= qual_next;
      ack_cnt  <= ack_next;
      busy     <= busy_next;
      ack_n    <= ack_n_next;
    end
  end

  always_comb begin
    state_next = state;
    qual_next  = qual_cnt;
    ack_next   = ack_cnt;
    capture    = 1'b0;

    unique case (state)
      IDLE: begin
        // The sample that moves us to QUAL is the first qualifying one.
        if (!s_strobe_n && enable) begin
          state_next = QUAL;
          qual_next  = QW'(1);
        end
      end
      QUAL: begin
        if (!enable || s_strobe_n) begin
          state_next = IDLE;
          qual_next  = '0;
        end else if (qual_cnt + QW'(1) == QUAL_LAST) begin
          capture    = 1'b1;
          state_next = WAIT_HI;
          qual_next  = '0;
        end else begin
          qual_next  = qual_cnt + QW'(1);
        end
      end
      WAIT_HI: begin
        if (s_strobe_n) begin
          state_next = ACK;
          ack_next   = '0;
        end
      end
      ACK: begin
        if (ack_cnt == ACK_LAST) begin
          state_next = IDLE;
          ack_next   = '0;
        end else begin
          ack_next   = ack_cnt + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so that busy rises the
    // cycle after capture and the ack pulse is exactly ACK_CYCLES wide.
    busy_next  = (state_next == WAIT_HI) || (state_next == ACK) || !enable || full;
    ack_n_next = (state_next != ACK);
  end

  assign bus.pp_busy  = busy;
  assign bus.pp_ack_n = ack_n;

  // --------------------------------------------------------------------------
  // Receive FIFO, first-word-fall-through. The head byte is read straight
  // from storage at the read pointer, so it is stable until popped.
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign full         = (fifo_level == FULL_LEVEL);
  assign wr_en        = capture && !full;
  assign drop         = capture && full;
  assign bus.rx_valid = (fifo_level != '0);
  assign rd_en        = bus.rx_valid && bus.rx_ready;
  assign bus.rx_data  = bus.rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk32) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_level <= fifo_level + LW'(wr_en) - LW'(rd_en);
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_centronics_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_centronics_rx
//  Description : Self-checking bench for centronics_rx. A host model strobes
//                bytes, a scoreboard queue holds the bytes that must emerge,
//                and a monitor pops and compares on every stream transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_centronics_rx;
  localparam int FIFO_DEPTH = 16;
  localparam int STROBE_MIN = 8;
  localparam int ACK_CYCLES = 160;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk32       = 1'b0;
  logic          reset_n     = 1'b0;
  logic          enable      = 1'b1;
  logic          overrun_clr = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          overrun;

  centronics_rx_if bus();

  centronics_rx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .STROBE_MIN (STROBE_MIN),
    .ACK_CYCLES (ACK_CYCLES)
  ) dut (
    .clk32       (clk32),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus.slave),
    .fifo_level  (fifo_level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #16 clk32 = ~clk32;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         max_level = 0;
  bit         rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  // Host transaction: optionally wait for busy low, present the byte, hold
  // strobe low for 'low' clocks, then (for a qualifying strobe) measure ack.
  task automatic send(input logic [7:0] b, input int low, input bit push,
                      input bit wait_idle, output int lat, output int ackw);
    int k;
    lat  = 0;
    ackw = 0;
    if (wait_idle) begin
      k = 0;
      while (bus.pp_busy !== 1'b0 && k < 4000) begin
        cyc(1);
        k++;
      end
      if (k >= 4000) timeout("busy_release");
    end
    bus.pp_data = b;
    cyc(2);
    if (push) exp_q.push_back(b);
    bus.pp_strobe_n = 1'b0;
    for (int i = 1; i <= low; i++) begin
      @(negedge clk32);
      if (lat == 0 && bus.pp_busy === 1'b1) lat = i;
      cyc(1);
    end
    bus.pp_strobe_n = 1'b1;
    if (low >= STROBE_MIN) begin
      k = 0;
      while (bus.pp_ack_n !== 1'b0 && k < 100) begin
        @(negedge clk32);
        k++;
      end
      if (k >= 100) begin
        timeout("ack_start");
      end else begin
        while (bus.pp_ack_n === 1'b0 && ackw < 2000) begin
          ackw++;
          @(negedge clk32);
        end
      end
      cyc(1);
    end
  endtask

  task automatic wait_level(input int lvl, input string name);
    int k = 0;
    while (32'(fifo_level) != lvl && k < 500) begin
      cyc(1);
      k++;
    end
    chk(name, 32'(fifo_level), lvl);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  ackw;
    int  len;
    bit  bad_busy;
    bit  bad_ack;
    bit  seen;
    logic [7:0] b;

    bus.pp_strobe_n = 1'b1;
    bus.pp_data     = 8'h00;
    bus.rx_ready    = 1'b0;

    fork
      // Scoreboard monitor: compare every stream transfer with the queue.
      forever begin
        @(negedge clk32);
        if (reset_n) begin
          if (32'(fifo_level) > max_level) max_level = 32'(fifo_level);
          if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL rx_unexpected: got 0x%02h, required no byte", bus.rx_data);
            end else begin
              chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
          end
        end
      end
      // Random sink back-pressure, active only when requested.
      forever begin
        @(posedge clk32);
        #1;
        if (rand_ready) bus.rx_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // ---------------- reset values ----------------
    cyc(4);
    chk("rst_busy",     32'(bus.pp_busy),  1);
    chk("rst_ack_n",    32'(bus.pp_ack_n), 1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data",  32'(bus.rx_data),  0);
    chk("rst_level",    32'(fifo_level),   0);
    chk("rst_overrun",  32'(overrun),      0);
    reset_n = 1'b1;
    cyc(2);
    chk("busy_after_reset", 32'(bus.pp_busy), 0);

    // ---------------- basic byte, 1 us strobe ----------------
    bus.rx_ready = 1'b1;
    send(8'h41, 32, 1'b1, 1'b1, lat, ackw);
    chk("basic_busy_latency_in_window",
        32'((lat >= STROBE_MIN + 2) && (lat <= STROBE_MIN + 4)), 1);
    chk("basic_ack_width", 32'(ackw), ACK_CYCLES);
    cyc(2);
    chk("basic_busy_after", 32'(bus.pp_busy), 0);

    // ---------------- qualification boundary: exactly STROBE_MIN ----------
    send(8'h3C, STROBE_MIN, 1'b1, 1'b1, lat, ackw);
    chk("min_strobe_ack_width", 32'(ackw), ACK_CYCLES);

    // ---------------- glitches (incl. STROBE_MIN-1) ----------------
    for (int g = 0; g < 5; g++) begin
      len = (g == 0) ? STROBE_MIN - 1 : int'($urandom_range(1, STROBE_MIN - 1));
      send(8'($urandom), len, 1'b0, 1'b1, lat, ackw);
      bad_busy = 1'b0;
      bad_ack  = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk32);
        if (bus.pp_busy !== 1'b0) bad_busy = 1'b1;
        if (bus.pp_ack_n !== 1'b1) bad_ack = 1'b1;
      end
      cyc(1);
      chk("glitch_busy_stays_low", 32'(bad_busy | (lat != 0)), 0);
      chk("glitch_no_ack", 32'(bad_ack), 0);
    end
    chk("glitch_level", 32'(fifo_level), 0);

    // ---------------- random stream with random back-pressure ----------
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      send(8'($urandom), int'($urandom_range(STROBE_MIN + 1, 40)), 1'b1, 1'b1, lat, ackw);
    end
    rand_ready = 1'b0;
    cyc(1);
    bus.rx_ready = 1'b1;
    wait_level(0, "rand_drained_level");
    chk("rand_queue_empty", 32'(exp_q.size()), 0);
    chk("rand_no_overrun", 32'(overrun), 0);

    // ---------------- fill to full ----------------
    bus.rx_ready = 1'b0;
    for (int n = 0; n < FIFO_DEPTH; n++) begin
      send(8'(n), 20, 1'b1, 1'b1, lat, ackw);
    end
    cyc(5);
    chk("fill_level", 32'(fifo_level), FIFO_DEPTH);
    chk("fill_busy_held", 32'(bus.pp_busy), 1);
    chk("fill_no_overrun_yet", 32'(overrun), 0);
    send(8'hEE, 20, 1'b0, 1'b0, lat, ackw);
    cyc(2);
    chk("overrun_set", 32'(overrun), 1);
    chk("overrun_level", 32'(fifo_level), FIFO_DEPTH);
    chk("overrun_busy", 32'(bus.pp_busy), 1);
    overrun_clr = 1'b1;
    cyc(1);
    overrun_clr = 1'b0;
    cyc(1);
    chk("overrun_cleared", 32'(overrun), 0);

    // ---------------- drain in order ----------------
    bus.rx_ready = 1'b1;
    wait_level(0, "drain_level");
    cyc(3);
    chk("drain_queue_empty", 32'(exp_q.size()), 0);
    chk("drain_busy_low", 32'(bus.pp_busy), 0);

    // ---------------- concurrent streaming with an always-ready sink -------
    max_level = 0;
    for (int n = 0; n < 6; n++) begin
      b = (n % 2 == 0) ? 8'h55 : 8'hAA;
      send(b, int'($urandom_range(STROBE_MIN + 1, 30)), 1'b1, 1'b1, lat, ackw);
    end
    cyc(4);
    chk("concurrent_max_level_le1", 32'(max_level <= 1), 1);
    chk("concurrent_queue_empty", 32'(exp_q.size()), 0);

    // ---------------- enable dropped during qualification ----------------
    bus.pp_data = 8'h99;
    cyc(2);
    bus.pp_strobe_n = 1'b0;
    cyc(5);
    enable = 1'b0;
    cyc(10);
    bus.pp_strobe_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk32);
      if (bus.pp_ack_n !== 1'b1) seen = 1'b1;
    end
    cyc(1);
    chk("disable_no_ack", 32'(seen), 0);
    chk("disable_busy", 32'(bus.pp_busy), 1);
    chk("disable_level", 32'(fifo_level), 0);
    enable = 1'b1;
    cyc(2);
    chk("reenable_busy_low", 32'(bus.pp_busy), 0);

    // ---------------- asynchronous reset in the middle of ACK -------------
    bus.rx_ready = 1'b0;
    bus.pp_data  = 8'h77;
    cyc(2);
    exp_q.push_back(8'h77);
    bus.pp_strobe_n = 1'b0;
    cyc(20);
    bus.pp_strobe_n = 1'b1;
    len = 0;
    while (bus.pp_ack_n !== 1'b0 && len < 100) begin
      cyc(1);
      len++;
    end
    if (len >= 100) timeout("reset_ack_start");
    cyc(20);
    chk("pre_reset_level", 32'(fifo_level), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ack_n",    32'(bus.pp_ack_n), 1);
    chk("async_rst_busy",     32'(bus.pp_busy),  1);
    chk("async_rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("async_rst_level",    32'(fifo_level),   0);
    exp_q.delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("post_reset_busy_low", 32'(bus.pp_busy), 0);
    chk("post_reset_ack_n",    32'(bus.pp_ack_n), 1);

    // One more byte after reset to confirm the FIFO restarted cleanly.
    bus.rx_ready = 1'b1;
    send(8'hC3, 16, 1'b1, 1'b1, lat, ackw);
    cyc(4);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/centronics_rx.md
Name: centronics_rx

Overview:
- Peripheral-side (printer-end) Centronics parallel-port responder.
- Accepts bytes strobed by a host over pp_strobe_n/pp_data and paces the host with pp_busy and pp_ack_n.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream toward the MCU/SPI side.
- Sits in the FPGA toplevel in place of an external printer, so the ST parallel port can be used by the FPGA-side byte sink.

Parameters:
- FIFO_DEPTH, 16: receive FIFO entries; must be a power of 2, minimum 2.
- STROBE_MIN, 8: consecutive synchronized-low clk32 samples needed to qualify a strobe (glitch filter).
- ACK_CYCLES, 160: pp_ack_n low pulse width in clk32 cycles (5 us at 32 MHz).

Ports:
- clk32, input, 1: 32 MHz system clock; the only clock.
- reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: receiver enabled. When 0, strobes are ignored and pp_busy=1.
- pp_strobe_n, input, 1: host strobe, active low, asynchronous to clk32.
- pp_data, input, 8: host data, asynchronous to clk32.
- pp_busy, output, 1: busy toward host, active high.
- pp_ack_n, output, 1: acknowledge pulse toward host, active low.
- rx_data, output, 8: head-of-FIFO byte.
- rx_valid, output, 1: rx_data is valid.
- rx_ready, input, 1: sink accepts rx_data. A transfer occurs when rx_valid & rx_ready.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- overrun, output, 1: sticky flag; a byte was dropped.
- overrun_clr, input, 1: clears overrun.

Behaviour:
- Reset values: pp_busy=1, pp_ack_n=1, rx_valid=0, rx_data=0, fifo_level=0, overrun=0, FSM=IDLE, all counters 0.
- Input synchronization:
  - pp_strobe_n and pp_data each pass through a 2-flop synchronizer.
  - All logic below uses only the synchronized copies (s_strobe_n, s_data).
- FSM states IDLE, QUAL, WAIT_HI, ACK:
  - IDLE: pp_busy = ~enable | fifo_full. When s_strobe_n=0 and enable=1, go to QUAL with qual_cnt=1.
  - QUAL: each cycle with s_strobe_n=0, qual_cnt increments.
    - If s_strobe_n=1 before the count reaches STROBE_MIN, treat it as a glitch: return to IDLE, no capture.
    - On the cycle qual_cnt reaches STROBE_MIN, capture s_data. Write it to the FIFO if not full; otherwise drop it and set overrun. Go to WAIT_HI.
    - pp_busy=1 from the cycle after capture.
  - WAIT_HI: pp_busy=1. Wait for s_strobe_n=1, then go to ACK with ack_cnt=0 and pp_ack_n=0.
  - ACK: pp_busy=1, pp_ack_n=0 for exactly ACK_CYCLES cycles. Then pp_ack_n=1 and go to IDLE. pp_busy drops in IDLE only if the FIFO is not full.
- Latency: from pp_strobe_n falling at the pin, capture occurs STROBE_MIN+2 cycles later (±1 for synchronizer phase).
- FIFO:
  - Registered first-word-fall-through.
  - rx_valid rises the cycle after the write edge.
  - Simultaneous write and read: occupancy is unchanged and both operations take effect.
  - Full when fifo_level=FIFO_DEPTH. Read/write pointers wrap modulo FIFO_DEPTH.
  - rx_data holds its value while rx_valid=1 and rx_ready=0.
- Overrun:
  - Set on a dropped capture.
  - overrun_clr clears it. If a set and a clear occur in the same cycle, set wins.
- enable deasserted:
  - In QUAL: return to IDLE immediately, no capture.
  - In WAIT_HI or ACK: the current handshake completes normally, then the block stays busy in IDLE.
  - FIFO contents are retained.
- Asynchronous reset mid-handshake: all outputs return to their reset values immediately. The FIFO is emptied.

Test Plan:
- Basic byte: enable=1, rx_ready=1, host drives 0x41 with strobe low for 1 us → pp_busy rises ~10 cycles after strobe falls; rx_data=0x41 with rx_valid pulsed 1 cycle; pp_ack_n low for exactly 160 cycles after strobe rises; pp_busy=0 afterward.
- Glitch: strobe low for 4 cycles → no FIFO write, pp_busy stays 0, pp_ack_n stays 1.
- Fill: rx_ready=0, send bytes 0x00..0x0F → fifo_level=16, pp_busy stays 1 after the 16th ack. Then a 17th forced strobe → byte dropped, overrun=1. Pulse overrun_clr → overrun=0.
- Drain order: from the full state, assert rx_ready=1 → bytes 0x00..0x0F emerge in order; fifo_level reaches 0; pp_busy falls once the FIFO is not full and the FSM is in IDLE.
- Concurrent: host streams 0x55 and 0xAA while the sink reads every cycle, with a write and read coinciding → fifo_level never exceeds 1 and no data is lost.
- Reset mid-ACK: assert reset_n=0 during pp_ack_n low → pp_ack_n=1, pp_busy=1, rx_valid=0 immediately. After release with enable=1 → pp_busy=0 within 2 cycles.
